// File: rtl/secded_scrubber.sv
// Background scrubber for 72-bit SECDED codewords {c[7:0], d[63:0]}: reads every
// word, rewrites single-bit errors in place, counts and logs uncorrectable ones.
module secded_scrubber #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [71:0]       mem_wdata,
    input  logic [71:0]       mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [15:0]       corr_cnt,
    output logic [15:0]       uncorr_cnt,
    output logic [ADDR_W-1:0] last_err_addr
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        CHECK,
        WRITE,
        NEXT,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    // Hamming position of data bit j: the (j+1)-th non-power-of-two in 3..71.
    function automatic int data_pos(input int j);
        int cnt;
        int res;
        cnt = 0;
        res = 0;
        for (int p = 3; p < 72; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == j) res = p;
                cnt = cnt + 1;
            end
        end
        return res;
    endfunction

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg;
    logic [71:0]       rdata_reg;
    logic [71:0]       wdata_reg;
    logic [15:0]       corr_reg;
    logic [15:0]       uncorr_reg;
    logic [ADDR_W-1:0] err_addr_reg;

    logic [71:0] ham;
    logic [71:0] flip_ham;
    logic [71:0] ham_fixed;
    logic [71:0] fixed_word;
    logic [6:0]  syn;
    logic        par;
    logic        fixable;
    logic        uncorrectable;

    // Reorder the stored word by Hamming position; position 0 is unused and tied low.
    assign ham[0] = 1'b0;
    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_data_map
            localparam int P = data_pos(gi);
            assign ham[P]         = rdata_reg[gi];
            assign fixed_word[gi] = ham_fixed[P];
        end
        for (genvar gi = 0; gi < 7; gi++) begin : g_check_map
            assign ham[1 << gi]        = rdata_reg[64 + gi];
            assign fixed_word[64 + gi] = ham_fixed[1 << gi];
        end
    endgenerate

    // The syndrome is the XOR of the positions of all set bits, which equals
    // recomputed check bits XOR stored check bits.
    always_comb begin
        syn = '0;
        for (int p = 1; p < 72; p++) begin
            if (ham[p]) syn = syn ^ 7'(p);
        end
    end

    assign par           = ^rdata_reg;
    assign fixable       = par && (syn <= 7'd71);
    assign uncorrectable = (!par && (syn != 7'd0)) || (par && (syn > 7'd71));

    always_comb begin
        flip_ham = '0;
        for (int p = 1; p < 72; p++) begin
            flip_ham[p] = par && (syn == 7'(p));
        end
    end

    assign ham_fixed      = ham ^ flip_ham;
    assign fixed_word[71] = rdata_reg[71] ^ (par && (syn == 7'd0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start && !abort) state_next = READ;
            READ:    if (mem_gnt) state_next = WAIT;
            WAIT:    state_next = CHECK;
            CHECK:   state_next = fixable ? WRITE : NEXT;
            WRITE:   if (mem_gnt) state_next = NEXT;
            NEXT:    state_next = (ptr_reg == LAST_ADDR) ? DONE : READ;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if ((state_reg != IDLE) && abort) state_next = IDLE;
    end

    // Counter and write-data updates are suppressed on an aborting edge so the
    // values left behind reflect only fully processed words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg      <= '0;
            rdata_reg    <= '0;
            wdata_reg    <= '0;
            corr_reg     <= '0;
            uncorr_reg   <= '0;
            err_addr_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start && !abort) begin
                        ptr_reg    <= '0;
                        corr_reg   <= '0;
                        uncorr_reg <= '0;
                    end
                end
                WAIT: rdata_reg <= mem_rdata;
                CHECK: begin
                    if (!abort) begin
                        if (fixable) begin
                            wdata_reg <= fixed_word;
                            if (corr_reg != 16'hFFFF) corr_reg <= corr_reg + 16'd1;
                        end else if (uncorrectable) begin
                            err_addr_reg <= ptr_reg;
                            if (uncorr_reg != 16'hFFFF) uncorr_reg <= uncorr_reg + 16'd1;
                        end
                    end
                end
                NEXT: begin
                    if (!abort && (ptr_reg != LAST_ADDR)) ptr_reg <= ptr_reg + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign mem_req       = (state_reg == READ) || (state_reg == WRITE);
    assign mem_we        = (state_reg == WRITE);
    assign mem_addr      = ptr_reg;
    assign mem_wdata     = wdata_reg;
    assign busy          = (state_reg != IDLE);
    assign done          = (state_reg == DONE);
    assign corr_cnt      = corr_reg;
    assign uncorr_cnt    = uncorr_reg;
    assign last_err_addr = err_addr_reg;

endmodule

// File: tb/tb_secded_scrubber.sv
// Bench for secded_scrubber: a memory model, a spec-level encoder/error model
// and directed plus randomized scrub passes.
module tb_secded_scrubber;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic start   = 1'b0;
    logic abort   = 1'b0;
    logic mem_gnt = 1'b1;
    logic load    = 1'b0;

    logic              mem_req, mem_we, busy, done;
    logic [ADDR_W-1:0] mem_addr, last_err_addr;
    logic [71:0]       mem_wdata;
    logic [71:0]       mem_rdata = '0;
    logic [15:0]       corr_cnt, uncorr_cnt;

    int checks   = 0;
    int failures = 0;

    logic [71:0] mem  [DEPTH];
    logic [71:0] img  [DEPTH];
    logic [71:0] orig [DEPTH];
    int          nflip[DEPTH];
    int          wr_addr_q[$];
    logic [71:0] wr_data_q[$];
    int          wr_base  = 0;
    int          exp_last = 0;

    always #5 clk = ~clk;

    secded_scrubber #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .mem_req      (mem_req),
        .mem_gnt      (mem_gnt),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .busy         (busy),
        .done         (done),
        .corr_cnt     (corr_cnt),
        .uncorr_cnt   (uncorr_cnt),
        .last_err_addr(last_err_addr)
    );

    // Memory: read data appears one cycle after an accepted read.
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= img[i];
        end else if (mem_req && mem_gnt) begin
            if (mem_we) begin
                mem[mem_addr] <= mem_wdata;
                wr_addr_q.push_back(int'(mem_addr));
                wr_data_q.push_back(mem_wdata);
                $display("write addr=%0d data=%018h", mem_addr, mem_wdata);
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    task automatic check_val(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] encode(input logic [63:0] d);
        logic [7:0] c;
        int p;
        c = '0;
        p = 3;
        for (int j = 0; j < 64; j++) begin
            while ((p & (p - 1)) == 0) p++;
            for (int i = 0; i < 7; i++) if (p[i]) c[i] = c[i] ^ d[j];
            p++;
        end
        c[7] = ^{c[6:0], d};
        return {c, d};
    endfunction

    task automatic clear_img();
        for (int a = 0; a < DEPTH; a++) begin
            orig[a]  = '0;
            img[a]   = '0;
            nflip[a] = 0;
        end
    endtask

    task automatic inject(input int a, input int b0, input int b1);
        img[a][b0] = ~img[a][b0];
        nflip[a]++;
        if (b1 >= 0) begin
            img[a][b1] = ~img[a][b1];
            nflip[a]++;
        end
    endtask

    task automatic random_img();
        int r, b0, b1;
        for (int a = 0; a < DEPTH; a++) begin
            orig[a]  = encode({$urandom(), $urandom()});
            img[a]   = orig[a];
            nflip[a] = 0;
            r = $urandom_range(0, 9);
            b0 = $urandom_range(0, 71);
            if (r >= 6 && r <= 8) inject(a, b0, -1);
            if (r == 9) begin
                b1 = (b0 + 1 + $urandom_range(0, 70)) % 72;
                inject(a, b0, b1);
            end
        end
    endtask

    task automatic load_mem();
        @(negedge clk);
        load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    // mode 0: gnt high; 1: five-cycle stall on the read of addr 2;
    // 2: random gnt; 3: abort while a write is stalled.
    task automatic run_pass(input int mode, output int done_cyc);
        int done_cnt, stall_left;
        bit aborted;
        done_cyc   = 0;
        done_cnt   = 0;
        stall_left = 5;
        aborted    = 1'b0;
        wr_base    = wr_addr_q.size();
        mem_gnt    = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 4000; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check_val("first_req", mem_req, 1'b1);
                check_val("first_addr", mem_addr, 0);
                check_val("start_corr_clr", corr_cnt, 0);
                check_val("start_uncorr_clr", uncorr_cnt, 0);
            end
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = n;
            end
            if (aborted) begin
                check_val("abort_busy", busy, 1'b0);
                abort   = 1'b0;
                mem_gnt = 1'b1;
                break;
            end
            if (!busy) break;
            case (mode)
                1: begin
                    if (stall_left < 5 && stall_left > 0) begin
                        check_val("stall_req", mem_req, 1'b1);
                        check_val("stall_we", mem_we, 1'b0);
                        check_val("stall_addr", mem_addr, 2);
                        mem_gnt = 1'b0;
                        stall_left--;
                    end else if (stall_left == 5 && mem_req && !mem_we && mem_addr == 2) begin
                        mem_gnt = 1'b0;
                        stall_left--;
                    end else begin
                        mem_gnt = 1'b1;
                    end
                end
                2: mem_gnt = ($urandom_range(0, 3) != 0);
                3: begin
                    if (mem_req && mem_we) begin
                        mem_gnt = 1'b0;
                        abort   = 1'b1;
                        aborted = 1'b1;
                    end else begin
                        mem_gnt = 1'b1;
                    end
                end
                default: mem_gnt = 1'b1;
            endcase
        end
        if (mode == 3) begin
            repeat (4) begin
                @(negedge clk);
                if (done) done_cnt++;
            end
            check_val("abort_seen", aborted, 1'b1);
            check_val("abort_no_done", done_cnt, 0);
            check_val("abort_no_write", wr_addr_q.size() - wr_base, 0);
        end else begin
            check_val("done_pulses", done_cnt, 1);
        end
        mem_gnt = 1'b1;
    endtask

    task automatic verify(input string tag);
        int ec, eu, nwr;
        int ea[$];
        ec = 0;
        eu = 0;
        for (int a = 0; a < DEPTH; a++) begin
            if (nflip[a] == 1) begin
                ec++;
                ea.push_back(a);
            end else if (nflip[a] == 2) begin
                eu++;
                exp_last = a;
            end
        end
        check_val({tag, "_corr_cnt"}, corr_cnt, ec);
        check_val({tag, "_uncorr_cnt"}, uncorr_cnt, eu);
        check_val({tag, "_last_err"}, last_err_addr, exp_last);
        nwr = wr_addr_q.size() - wr_base;
        check_val({tag, "_num_writes"}, nwr, ea.size());
        for (int i = 0; i < ea.size() && i < nwr; i++) begin
            check_val({tag, "_wr_addr"}, wr_addr_q[wr_base + i], ea[i]);
            check_val({tag, "_wr_data"}, wr_data_q[wr_base + i], orig[ea[i]]);
        end
        for (int a = 0; a < DEPTH; a++) begin
            check_val({tag, "_mem"}, mem[a], (nflip[a] == 2) ? img[a] : orig[a]);
        end
        $display("pass %s corr=%0d uncorr=%0d last=%0d writes=%0d", tag, corr_cnt, uncorr_cnt,
                 last_err_addr, nwr);
    endtask

    initial begin
        int dc;
        repeat (3) @(negedge clk);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        check_val("rst_req", mem_req, 1'b0);
        check_val("rst_we", mem_we, 1'b0);
        check_val("rst_addr", mem_addr, 0);
        check_val("rst_wdata", mem_wdata, 72'h0);
        check_val("rst_corr", corr_cnt, 0);
        check_val("rst_uncorr", uncorr_cnt, 0);
        check_val("rst_last", last_err_addr, 0);
        rst_n = 1'b1;

        clear_img();
        load_mem();
        run_pass(0, dc);
        check_val("clean_done_cycle", dc, 4 * DEPTH + 1);
        verify("clean");

        clear_img();
        inject(3, 0, -1);
        load_mem();
        run_pass(0, dc);
        check_val("d0_done_cycle", dc, 4 * DEPTH + 2);
        verify("d0");

        clear_img();
        inject(5, 71, -1);
        inject(9, 64, -1);
        load_mem();
        run_pass(0, dc);
        check_val("chk_done_cycle", dc, 4 * DEPTH + 3);
        verify("chkbits");

        clear_img();
        inject(7, 0, 1);
        load_mem();
        run_pass(0, dc);
        check_val("dbl_done_cycle", dc, 4 * DEPTH + 1);
        verify("double");

        clear_img();
        load_mem();
        run_pass(1, dc);
        check_val("stall_done_cycle", dc, 4 * DEPTH + 6);
        verify("stall");

        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check_val("start_abort_busy", busy, 1'b0);
        check_val("start_abort_req", mem_req, 1'b0);

        clear_img();
        inject(3, 0, -1);
        load_mem();
        run_pass(3, dc);
        run_pass(0, dc);
        check_val("rescan_done_cycle", dc, 4 * DEPTH + 2);
        verify("rescan");

        for (int k = 0; k < 6; k++) begin
            random_img();
            load_mem();
            run_pass(2, dc);
            verify("random");
        end

        clear_img();
        inject(3, 0, -1);
        load_mem();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (25) @(negedge clk);
        rst_n = 1'b0;
        #1;
        wr_base = wr_addr_q.size();
        check_val("midrst_busy", busy, 1'b0);
        check_val("midrst_req", mem_req, 1'b0);
        check_val("midrst_addr", mem_addr, 0);
        check_val("midrst_corr", corr_cnt, 0);
        check_val("midrst_last", last_err_addr, 0);
        repeat (3) @(negedge clk);
        check_val("midrst_no_write", wr_addr_q.size() - wr_base, 0);
        check_val("midrst_idle", busy, 1'b0);
        rst_n = 1'b1;
        exp_last = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
